// File: rtl/multi_phase_light_ctrl_if.sv
// Bundles the controls and lamp/status outputs of multi_phase_light_ctrl.
//   slave  : controller side (tick/skip/hold/set_mode[/flash] in; lamps, active_dir, phase, remain out)
//   master : driver/observer side, directions mirrored
// Optional macro LIGHT_FLASH_EN adds the flash request signal.
interface multi_phase_light_ctrl_if #(
  parameter int unsigned NUM_DIR = 2,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

  logic               tick;
  logic               skip;
  logic               hold;
  logic               set_mode;
`ifdef LIGHT_FLASH_EN
  logic               flash;
`endif
  logic [NUM_DIR-1:0] red;
  logic [NUM_DIR-1:0] yellow;
  logic [NUM_DIR-1:0] green;
  logic [DIR_W-1:0]   active_dir;
  logic [1:0]         phase;
  logic [CNT_W-1:0]   remain;

  modport slave (
    output red, yellow, green, active_dir, phase, remain,
    input  tick, skip, hold, set_mode
`ifdef LIGHT_FLASH_EN
    , flash
`endif
  );

  modport master (
    input  red, yellow, green, active_dir, phase, remain,
    output tick, skip, hold, set_mode
`ifdef LIGHT_FLASH_EN
    , flash
`endif
  );
endinterface

// File: rtl/multi_phase_light_ctrl.sv
// Round-robin traffic light controller for NUM_DIR approaches.
// Each approach gets GREEN then YELLOW, separated by an ALL_RED interval;
// phase timing counts tick strobes. skip forces the next transition, hold
// freezes, set_mode restarts at ALL_RED/approach 0.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : multi_phase_light_ctrl_if.slave (controls in, lamps/status out)
// Optional macro LIGHT_FLASH_EN adds the flash input and the FLASH phase
// (all-yellow blinking, toggled on every tick).
module multi_phase_light_ctrl #(
  parameter int unsigned NUM_DIR  = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_GREEN  = 20,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 2
) (
  input logic                      clk,
  input logic                      rst,
  multi_phase_light_ctrl_if.slave  bus
);
  localparam int unsigned DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [DIR_W-1:0] DIR_LAST  = DIR_W'(NUM_DIR - 1);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
`ifdef LIGHT_FLASH_EN
    , ST_FLASH = 2'd3
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [NUM_DIR-1:0] red_q, red_d;
  logic [NUM_DIR-1:0] yellow_q, yellow_d;
  logic [NUM_DIR-1:0] green_q, green_d;
  logic [NUM_DIR-1:0] onehot;
  logic               advance;
`ifdef LIGHT_FLASH_EN
  logic               flash_on_q, flash_on_d;
`endif

  // Next-state, timer and approach selection in priority order.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    remain_d = remain_q;
    advance  = 1'b0;
`ifdef LIGHT_FLASH_EN
    flash_on_d = flash_on_q;
`endif
    if (bus.set_mode) begin
      state_d  = ST_ALL_RED;
      dir_d    = '0;
      remain_d = LD_ALLRED;
    end
`ifdef LIGHT_FLASH_EN
    else if (bus.flash && (state_q != ST_FLASH)) begin
      state_d    = ST_FLASH;
      flash_on_d = 1'b1;
    end else if (!bus.flash && (state_q == ST_FLASH)) begin
      state_d  = ST_ALL_RED;
      dir_d    = '0;
      remain_d = LD_ALLRED;
    end else if (state_q == ST_FLASH) begin
      // skip and hold have no effect while flashing
      if (bus.tick) begin
        flash_on_d = ~flash_on_q;
      end
    end
`endif
    else if (bus.skip) begin
      advance = 1'b1;
    end else if (!bus.hold && bus.tick) begin
      if (remain_q != '0) begin
        remain_d = remain_q - CNT_W'(1);
      end else begin
        advance = 1'b1;
      end
    end

    if (advance) begin
      case (state_q)
        ST_ALL_RED: begin
          state_d  = ST_GREEN;
          remain_d = LD_GREEN;
        end
        ST_GREEN: begin
          state_d  = ST_YELLOW;
          remain_d = LD_YELLOW;
        end
        default: begin
          // YELLOW hands the cycle to the next approach
          state_d  = ST_ALL_RED;
          remain_d = LD_ALLRED;
          dir_d    = (dir_q == DIR_LAST) ? '0 : dir_q + DIR_W'(1);
        end
      endcase
    end
  end

  // Lamp decode of the next state so registered lamps track state_q exactly.
  always_comb begin
    onehot   = NUM_DIR'(1) << dir_d;
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    case (state_d)
      ST_GREEN: begin
        green_d = onehot;
        red_d   = ~onehot;
      end
      ST_YELLOW: begin
        yellow_d = onehot;
        red_d    = ~onehot;
      end
`ifdef LIGHT_FLASH_EN
      ST_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_DIR{flash_on_d}};
      end
`endif
      default: ;
    endcase
  end

  // State, timer and lamp registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ALL_RED;
      dir_q    <= '0;
      remain_q <= LD_ALLRED;
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
`ifdef LIGHT_FLASH_EN
      flash_on_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      remain_q <= remain_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
`ifdef LIGHT_FLASH_EN
      flash_on_q <= flash_on_d;
`endif
    end
  end

  assign bus.phase      = 2'(state_q);
  assign bus.active_dir = dir_q;
  assign bus.remain     = remain_q;
  assign bus.red        = red_q;
  assign bus.yellow     = yellow_q;
  assign bus.green      = green_q;

endmodule
